// File: rtl/pipe_add_sub_if.sv
// Operand/result handshake bundle for pipe_add_sub; `sat` exists only with PIPE_ADD_SUB_SAT_EN.
// slave = the adder's view, master = the issuing/consuming side.
interface pipe_add_sub_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             aluc;
`ifdef PIPE_ADD_SUB_SAT_EN
    logic             sat;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] r;
    logic             carry;
    logic             overflow;
    logic             zero;
    logic             negative;

    modport slave (
`ifdef PIPE_ADD_SUB_SAT_EN
        input  sat,
`endif
        input  in_valid, a, b, aluc, out_ready,
        output in_ready, out_valid, r, carry, overflow, zero, negative
    );

    modport master (
`ifdef PIPE_ADD_SUB_SAT_EN
        output sat,
`endif
        output in_valid, a, b, aluc, out_ready,
        input  in_ready, out_valid, r, carry, overflow, zero, negative
    );
endinterface

// File: rtl/pipe_add_sub.sv
// Pipelined add/sub with ALU flags, carry chain cut into STAGES slices; PIPE_ADD_SUB_SAT_EN adds overflow clamping.
// Latency STAGES cycles, one beat per cycle.
// Backpressure: every stage holds while out_valid & ~out_ready; in_ready = ~stall.
module pipe_add_sub #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    pipe_add_sub_if.slave bus
);
    localparam int W = WIDTH / STAGES;

    logic             stall;
    logic             adv;
    logic [WIDTH-1:0] b_cal;

    assign stall        = bus.out_valid & ~bus.out_ready;
    assign adv          = ~stall;
    assign bus.in_ready = adv;
    assign b_cal        = bus.aluc ? ~bus.b : bus.b;

    for (genvar k = 0; k < STAGES; k++) begin : stg
        localparam int LO = k * W;
        localparam int HI = LO + W - 1;

        logic              v_s;
        logic              aluc_s;
        logic              cin_s;
        logic [WIDTH-1:LO] a_s;
        logic [WIDTH-1:LO] b_s;
        logic [HI:0]       r_d;
        logic [W:0]        sum_d;
`ifdef PIPE_ADD_SUB_SAT_EN
        logic              sat_s;
`endif

        assign sum_d = {1'b0, a_s[HI:LO]} + {1'b0, b_s[HI:LO]} + {{W{1'b0}}, cin_s};

        // Slice 0 takes the subtract +1 as carry-in; later slices take the registered carry.
        if (k == 0) begin : src
            assign v_s    = bus.in_valid & adv;
            assign aluc_s = bus.aluc;
            assign cin_s  = bus.aluc;
            assign a_s    = bus.a;
            assign b_s    = b_cal;
            assign r_d    = sum_d[W-1:0];
`ifdef PIPE_ADD_SUB_SAT_EN
            assign sat_s  = bus.sat;
`endif
        end else begin : src
            assign v_s    = stg[k-1].mid.vld_q;
            assign aluc_s = stg[k-1].mid.aluc_q;
            assign cin_s  = stg[k-1].mid.c_q;
            assign a_s    = stg[k-1].mid.a_q;
            assign b_s    = stg[k-1].mid.b_q;
            assign r_d    = {sum_d[W-1:0], stg[k-1].mid.r_q};
`ifdef PIPE_ADD_SUB_SAT_EN
            assign sat_s  = stg[k-1].mid.sat_q;
`endif
        end

        if (k < STAGES - 1) begin : mid
            logic                vld_q;
            logic                aluc_q;
            logic                c_q;
            logic [HI:0]         r_q;
            logic [WIDTH-1:HI+1] a_q;
            logic [WIDTH-1:HI+1] b_q;
`ifdef PIPE_ADD_SUB_SAT_EN
            logic                sat_q;
`endif

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    vld_q  <= 1'b0;
                    aluc_q <= 1'b0;
                    c_q    <= 1'b0;
                    r_q    <= '0;
                    a_q    <= '0;
                    b_q    <= '0;
`ifdef PIPE_ADD_SUB_SAT_EN
                    sat_q  <= 1'b0;
`endif
                end else if (adv) begin
                    vld_q <= v_s;
                    if (v_s) begin
                        aluc_q <= aluc_s;
                        c_q    <= sum_d[W];
                        r_q    <= r_d;
                        a_q    <= a_s[WIDTH-1:HI+1];
                        b_q    <= b_s[WIDTH-1:HI+1];
`ifdef PIPE_ADD_SUB_SAT_EN
                        sat_q  <= sat_s;
`endif
                    end
                end
            end
        end else begin : fin
            logic [WIDTH-1:0] res_d;
            logic             ovf_d;
            logic             vld_q;
            logic [WIDTH-1:0] r_q;
            logic             carry_q;
            logic             ovf_q;
            logic             zero_q;
            logic             neg_q;

            assign ovf_d = (~a_s[WIDTH-1] & ~b_s[WIDTH-1] &  r_d[WIDTH-1]) |
                           ( a_s[WIDTH-1] &  b_s[WIDTH-1] & ~r_d[WIDTH-1]);

            always_comb begin
                res_d = r_d;
`ifdef PIPE_ADD_SUB_SAT_EN
                // On overflow both operands share A's sign, which picks the clamp rail.
                if (sat_s && ovf_d) begin
                    res_d = a_s[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
                end
`endif
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    vld_q   <= 1'b0;
                    r_q     <= '0;
                    carry_q <= 1'b0;
                    ovf_q   <= 1'b0;
                    zero_q  <= 1'b0;
                    neg_q   <= 1'b0;
                end else if (adv) begin
                    vld_q <= v_s;
                    if (v_s) begin
                        r_q     <= res_d;
                        carry_q <= aluc_s ^ sum_d[W];
                        ovf_q   <= ovf_d;
                        zero_q  <= (res_d == '0);
                        neg_q   <= res_d[WIDTH-1];
                    end
                end
            end
        end
    end

    assign bus.out_valid = stg[STAGES-1].fin.vld_q;
    assign bus.r         = stg[STAGES-1].fin.r_q;
    assign bus.carry     = stg[STAGES-1].fin.carry_q;
    assign bus.overflow  = stg[STAGES-1].fin.ovf_q;
    assign bus.zero      = stg[STAGES-1].fin.zero_q;
    assign bus.negative  = stg[STAGES-1].fin.neg_q;
endmodule

// File: tb/tb_pipe_add_sub.sv
// Bench for pipe_add_sub: a 32-bit/4-stage instance and an 8-bit/1-stage instance, selected by `sel`.
// Directed vector table, random streams with backpressure against an arithmetic model, reset mid-flight.
module tb_pipe_add_sub;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    int          sel;
    logic        in_valid_t, out_ready_t, aluc_t, sat_t;
    logic [31:0] a_t, b_t;

    logic        ov_t, ir_t;
    logic [31:0] r_t;
    logic [3:0]  f_t;  // {carry, overflow, zero, negative}

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] r;
        logic [3:0]  f;
    } res_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        aluc;
        logic        sat;
        logic [31:0] r;
        logic [3:0]  f;
    } vec_t;

    pipe_add_sub_if #(.WIDTH(32)) if32 ();
    pipe_add_sub_if #(.WIDTH(8))  if8 ();

    assign if32.in_valid  = in_valid_t & (sel == 0);
    assign if32.a         = a_t;
    assign if32.b         = b_t;
    assign if32.aluc      = aluc_t;
    assign if32.out_ready = out_ready_t;
    assign if8.in_valid   = in_valid_t & (sel == 1);
    assign if8.a          = a_t[7:0];
    assign if8.b          = b_t[7:0];
    assign if8.aluc       = aluc_t;
    assign if8.out_ready  = out_ready_t;
`ifdef PIPE_ADD_SUB_SAT_EN
    assign if32.sat       = sat_t;
    assign if8.sat        = sat_t;
`endif

    pipe_add_sub #(.WIDTH(32), .STAGES(4)) u32 (.clk(clk), .rst_n(rst_n), .bus(if32));
    pipe_add_sub #(.WIDTH(8),  .STAGES(1)) u8  (.clk(clk), .rst_n(rst_n), .bus(if8));

    always_comb begin
        if (sel == 0) begin
            ov_t = if32.out_valid;
            ir_t = if32.in_ready;
            r_t  = if32.r;
            f_t  = {if32.carry, if32.overflow, if32.zero, if32.negative};
        end else begin
            ov_t = if8.out_valid;
            ir_t = if8.in_ready;
            r_t  = {24'h0, if8.r};
            f_t  = {if8.carry, if8.overflow, if8.zero, if8.negative};
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", nm, act, exp);
        end
    endtask

    // Signed/unsigned reference arithmetic on plain integers.
    function automatic res_t model(input int w, input longint a, input longint b,
                                   input bit aluc, input bit sat);
        longint m, half, sa, sb, t, rr;
        bit     c, v;
        res_t   o;
        m    = longint'(1) << w;
        half = m >> 1;
        sa   = (a >= half) ? a - m : a;
        sb   = (b >= half) ? b - m : b;
        t    = aluc ? sa - sb : sa + sb;
        v    = (t >= half) || (t < -half);
        c    = aluc ? (a < b) : ((a + b) >= m);
        rr   = t % m;
        if (rr < 0) rr = rr + m;
        if (sat && v) rr = (t > 0) ? half - 1 : half;
        o.r  = rr[31:0];
        o.f  = {c, v, rr == 0, rr >= half};
        return o;
    endfunction

    function automatic logic [31:0] pick(input int w);
        logic [31:0] sp [4];
        logic [31:0] v;
        sp = '{32'h0, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000};
        if ($urandom_range(0, 3) == 0) v = sp[$urandom_range(0, 3)] >> (32 - w);
        else v = $urandom;
        if (w < 32) v = v & ((32'h1 << w) - 32'h1);
        return v;
    endfunction

    task automatic run_vec(input int i, input vec_t v, input int lat);
        int cnt;
        @(negedge clk);
        a_t = v.a; b_t = v.b; aluc_t = v.aluc; sat_t = v.sat;
        in_valid_t = 1'b1; out_ready_t = 1'b1;
        @(posedge clk);
        #1 in_valid_t = 1'b0;
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!ov_t && cnt < 20);
        chk($sformatf("vec%0d_latency", i), cnt, lat);
        chk($sformatf("vec%0d_r", i), r_t, v.r);
        chk($sformatf("vec%0d_flags", i), f_t, v.f);
    endtask

    task automatic stream(input int n, input int w);
        res_t q[$];
        res_t e;
        int   sent = 0, got = 0, cyc = 0;
        bit   prev_stall = 0, stall;
        logic [31:0] hr = '0;
        logic [3:0]  hf = '0;
        while (got < n && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            out_ready_t = ($urandom_range(0, 2) != 0);
            if (sent < n) begin
                in_valid_t = 1'b1;
                a_t        = pick(w);
                b_t        = pick(w);
                aluc_t     = 1'($urandom_range(0, 1));
`ifdef PIPE_ADD_SUB_SAT_EN
                sat_t      = 1'($urandom_range(0, 1));
`else
                sat_t      = 1'b0;
`endif
            end else begin
                in_valid_t = 1'b0;
            end
            #1;
            stall = ov_t && !out_ready_t;
            chk("in_ready_vs_stall", ir_t, !stall);
            if (prev_stall) begin
                chk("hold_valid", ov_t, 1);
                chk("hold_r", r_t, hr);
                chk("hold_flags", f_t, hf);
            end
            if (ov_t && out_ready_t) begin
                chk("out_has_expected", q.size() > 0, 1);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    chk($sformatf("w%0d_beat%0d_r", w, got), r_t, e.r);
                    chk($sformatf("w%0d_beat%0d_flags", w, got), f_t, e.f);
                end
                got++;
            end
            if (in_valid_t && ir_t) begin
                q.push_back(model(w, longint'(a_t), longint'(b_t), aluc_t, sat_t));
                sent++;
            end
            prev_stall = stall;
            hr = r_t;
            hf = f_t;
        end
        in_valid_t = 1'b0;
        chk("stream_complete", got, n);
    endtask

    task automatic midop_reset();
        bit seen = 0;
        @(negedge clk);
        out_ready_t = 1'b0; in_valid_t = 1'b1;
        a_t = 32'h11; b_t = 32'h22; aluc_t = 1'b0; sat_t = 1'b0;
        repeat (3) @(negedge clk);
        in_valid_t = 1'b0;
        rst_n      = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_mid_valid", ov_t, 0);
        chk("rst_mid_r", r_t, 0);
        chk("rst_mid_flags", f_t, 0);
        chk("rst_mid_in_ready", ir_t, 1);
        rst_n       = 1'b1;
        out_ready_t = 1'b1;
        repeat (10) begin
            @(negedge clk);
            #1 seen |= ov_t;
        end
        chk("rst_mid_no_stale", seen, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[$];
        tbl.push_back('{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 4'b0101});
        tbl.push_back('{32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0, 32'hFFFF_FFFE, 4'b1001});
        tbl.push_back('{32'h0000_0007, 32'h0000_0007, 1'b1, 1'b0, 32'h0000_0000, 4'b0010});
        tbl.push_back('{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 4'b1010});
        tbl.push_back('{32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 32'h7FFF_FFFF, 4'b0100});
        tbl.push_back('{32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0, 1'b0, 32'hFFFF_FFFE, 4'b0101});
        tbl.push_back('{32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 4'b0000});
        tbl.push_back('{32'h0000_0000, 32'h0000_0001, 1'b1, 1'b0, 32'hFFFF_FFFF, 4'b1001});
        tbl.push_back('{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 4'b1110});
`ifdef PIPE_ADD_SUB_SAT_EN
        tbl.push_back('{32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, 32'h8000_0000, 4'b0101});
        tbl.push_back('{32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0, 1'b1, 32'h7FFF_FFFF, 4'b0100});
`endif

        sel = 0; rst_n = 1'b0;
        in_valid_t = 1'b0; out_ready_t = 1'b0;
        a_t = '0; b_t = '0; aluc_t = 1'b0; sat_t = 1'b0;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = s;
            #1;
            chk($sformatf("reset%0d_valid", s), ov_t, 0);
            chk($sformatf("reset%0d_r", s), r_t, 0);
            chk($sformatf("reset%0d_flags", s), f_t, 0);
            chk($sformatf("reset%0d_in_ready", s), ir_t, 1);
        end
        sel   = 0;
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) run_vec(i, tbl[i], 4);

        stream(16, 32);
        stream(48, 32);
        midop_reset();

        sel = 1;
        stream(48, 8);
        midop_reset();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
